// File: rtl/fir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_pkg: FSM states, accumulator sizing and round/saturate helper        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int RS_W = 64;

  typedef struct packed {
    logic [RS_W-1:0] value;
    logic            sat;
  } rs_t;

  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // acc arrives already extended to RS_W according to sgn
  function automatic rs_t round_sat(input logic [RS_W-1:0] acc, input int shift,
                                    input int out_w, input logic sgn);
    rs_t             r;
    logic [RS_W-1:0] v;
    logic [RS_W-1:0] hi;
    logic [RS_W-1:0] lo;
    v     = acc;
    r.sat = 1'b0;
    if (shift > 0) v = v + (64'd1 << (shift - 1));
    if (sgn) v = $signed(v) >>> shift;
    else     v = v >> shift;
    if (sgn) begin
      hi = (64'd1 << (out_w - 1)) - 64'd1;
      lo = ~hi;
      if ($signed(v) > $signed(hi)) begin
        v     = hi;
        r.sat = 1'b1;
      end else if ($signed(v) < $signed(lo)) begin
        v     = lo;
        r.sat = 1'b1;
      end
    end else begin
      hi = (64'd1 << out_w) - 64'd1;
      lo = '0;
      if (v > hi) begin
        v     = hi;
        r.sat = 1'b1;
      end
    end
    r.value = v;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_round_sat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_round_sat: combinational round-half-up, shift and clamp to OUT_W     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W  = 28,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 11,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] value,
  output logic             sat
);

  logic [RS_W-1:0] acc_ext;
  rs_t             res;
  logic            unused_hi;

  assign acc_ext   = {{(RS_W-ACC_W){(SIGNED != 0) && acc[ACC_W-1]}}, acc};
  assign res       = round_sat(acc_ext, SHIFT, OUT_W, SIGNED != 0);
  assign value     = res.value[OUT_W-1:0];
  assign sat       = res.sat;
  // clamped result always fits OUT_W, upper bits carry no information
  assign unused_hi = ^res.value[RS_W-1:OUT_W];

endmodule
`default_nettype wire

// File: rtl/fir_serial_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_serial_mac: time-multiplexed FIR, one MAC iterated over NTAPS taps   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int NTAPS  = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 11,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         data_out,
  output logic                     sat_flag
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int IDX_W = $clog2(NTAPS);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  x [NTAPS];
  logic [COEF_W-1:0]  c [NTAPS];
  logic [IDX_W-1:0]   idx;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   x_ext, c_ext, prod;
  logic [OUT_W-1:0]   rs_value;
  logic               rs_sat;

  // Product kept at ACC_W bits: modular wrap is exact for two's complement
  always_comb begin
    x_ext = {{(ACC_W-DATA_W){(SIGNED != 0) && x[idx][DATA_W-1]}}, x[idx]};
    c_ext = {{(ACC_W-COEF_W){(SIGNED != 0) && c[idx][COEF_W-1]}}, c[idx]};
    prod  = x_ext * c_ext;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = en && !rst;
        if (in_valid && en) state_nxt = MAC;
      end
      MAC:     if (idx == IDX_W'(NTAPS - 1)) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!en) begin
        acc <= '0;
        idx <= '0;
        for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            x[0] <= data_in;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            acc <= '0;
            idx <= '0;
          end
          MAC: begin
            acc <= acc + prod;
            idx <= idx + 1'b1;
          end
          OUT: begin
            data_out  <= rs_value;
            sat_flag  <= rs_sat;
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Coefficients survive en low; only rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) c[k] <= '0;
    end else if (coef_we) begin
      c[coef_addr] <= coef_wdata;
    end
  end

  fir_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .SIGNED(SIGNED)
  ) u_round_sat (
    .acc  (acc),
    .value(rs_value),
    .sat  (rs_sat)
  );

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_mac.sv
`default_nettype none
// Scoreboard bench: unsigned default instance plus a small signed instance,
// expected results from a plain-arithmetic FIR model.
module tb_fir_serial_mac;

  localparam int NT   = 16;
  localparam int NT_S = 4;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [11:0] data_in = '0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [11:0] coef_wdata = '0;
  logic        out_valid;
  logic [15:0] data_out;
  logic        sat_flag;

  logic        in_valid_s = 1'b0, in_ready_s;
  logic [11:0] data_in_s = '0;
  logic        coef_we_s = 1'b0;
  logic [1:0]  coef_addr_s = '0;
  logic [11:0] coef_wdata_s = '0;
  logic        out_valid_s;
  logic [15:0] data_out_s;
  logic        sat_flag_s;

  always #5 clk = ~clk;

  fir_serial_mac dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .data_out(data_out), .sat_flag(sat_flag)
  );

  fir_serial_mac #(.NTAPS(NT_S), .SHIFT(0), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .data_in(data_in_s), .coef_we(coef_we_s), .coef_addr(coef_addr_s), .coef_wdata(coef_wdata_s),
    .out_valid(out_valid_s), .data_out(data_out_s), .sat_flag(sat_flag_s)
  );

  typedef struct {
    longint val;
    bit     sat;
    int     due;
  } exp_t;

  exp_t   exp_q[$], exp_s[$];
  exp_t   e_obs, e_mon, e_mon_s, e_snd;
  int     checks = 0, failures = 0, cyc = 0;
  longint xs[NT], cs[NT], fxs[NT], fcs[NT], xs_s[NT], cs_s[NT];
  bit     inflight = 1'b0, hold = 1'b0;
  int     age = 0, acc_cyc = 0, last_acc = -1, n_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint sx(input longint v, input bit sgn);
    return (sgn && v[11]) ? v - 4096 : v;
  endfunction

  // Direct FIR definition: sum c[k]*x[k], round half up, shift, clamp
  function automatic void model(input longint xv[NT], input longint cv[NT], input int n,
                                input int shift, input bit sgn, output longint val, output bit sat);
    longint a, hi, lo;
    a = 0;
    for (int k = 0; k < n; k++) a += sx(xv[k], sgn) * sx(cv[k], sgn);
    if (shift > 0) a += longint'(1) << (shift - 1);
    a   = a >>> shift;
    hi  = sgn ? 32767 : 65535;
    lo  = sgn ? -32768 : 0;
    sat = 1'b0;
    if (a > hi) begin a = hi; sat = 1'b1; end
    if (a < lo) begin a = lo; sat = 1'b1; end
    val = a & 64'hFFFF;
  endfunction

  // Observer: acceptances, coefficient writes and aborts as seen on the ports
  always @(negedge clk) begin
    if (!hold) last_acc = -1;
    if (rst) begin
      for (int k = 0; k < NT; k++) begin xs[k] = 0; cs[k] = 0; end
      inflight = 1'b0;
    end else if (!en) begin
      for (int k = 0; k < NT; k++) xs[k] = 0;
      inflight = 1'b0;
      if (coef_we) cs[coef_addr] = coef_wdata;
    end else begin
      if (inflight) begin
        age++;
        // write landing at edge age is seen by taps consumed after that edge
        if (coef_we && int'(coef_addr) >= age) fcs[coef_addr] = coef_wdata;
        if (age == NT) begin
          model(fxs, fcs, NT, 11, 1'b0, e_obs.val, e_obs.sat);
          e_obs.due = acc_cyc + NT + 1;
          exp_q.push_back(e_obs);
          inflight = 1'b0;
        end
      end
      if (coef_we) cs[coef_addr] = coef_wdata;
      if (in_valid && in_ready) begin
        for (int k = NT - 1; k > 0; k--) xs[k] = xs[k-1];
        xs[0] = data_in;
        fxs = xs;
        fcs = cs;
        inflight = 1'b1;
        age = 0;
        acc_cyc = cyc + 1;
        if (hold && last_acc >= 0) chk("accept_spacing", (cyc + 1 - last_acc) == NT + 2, cyc + 1 - last_acc, NT + 2);
        last_acc = cyc + 1;
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 1'b0, data_out, -1);
      else begin
        e_mon = exp_q.pop_front();
        chk("data_out", data_out == 16'(e_mon.val), data_out, e_mon.val);
        chk("sat_flag", sat_flag == e_mon.sat, sat_flag, e_mon.sat);
        chk("out_latency", cyc == e_mon.due, cyc, e_mon.due);
        chk("ready_with_valid", in_ready == 1'b1, in_ready, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid_s) begin
      if (exp_s.size() == 0) chk("s_unexpected_out_valid", 1'b0, data_out_s, -1);
      else begin
        e_mon_s = exp_s.pop_front();
        chk("s_data_out", data_out_s == 16'(e_mon_s.val), data_out_s, e_mon_s.val);
        chk("s_sat_flag", sat_flag_s == e_mon_s.sat, sat_flag_s, e_mon_s.sat);
        chk("s_out_latency", cyc == e_mon_s.due, cyc, e_mon_s.due);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    coef_we = 1'b1; coef_addr = 4'(addr); coef_wdata = 12'(data);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input int s);
    int  n;
    bit  ok;
    n = 0; ok = 1'b0;
    in_valid = 1'b1; data_in = 12'(s);
    do begin
      @(negedge clk); ok = in_ready;
      tick(); n++;
    end while (!ok && n < 200);
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 1'b0, n, 200);
  endtask

  task automatic wr_s(input int addr, input int data);
    coef_we_s = 1'b1; coef_addr_s = 2'(addr); coef_wdata_s = 12'(data);
    cs_s[addr] = data;
    tick();
    coef_we_s = 1'b0;
  endtask

  task automatic send_s(input int s);
    int n;
    n = 0;
    in_valid_s = 1'b1; data_in_s = 12'(s);
    @(negedge clk);
    while (!in_ready_s && n < 200) begin n++; @(negedge clk); end
    if (!in_ready_s) chk("send_s_timeout", 1'b0, n, 200);
    else begin
      for (int k = NT - 1; k > 0; k--) xs_s[k] = xs_s[k-1];
      xs_s[0] = s;
      model(xs_s, cs_s, NT_S, 0, 1'b1, e_snd.val, e_snd.sat);
      e_snd.due = cyc + 1 + NT_S + 1;
      exp_s.push_back(e_snd);
    end
    tick();
    in_valid_s = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || inflight || exp_s.size() != 0) && n < 500) begin tick(); n++; end
    if (n >= 500) chk("drain_timeout", 1'b0, exp_q.size() + exp_s.size(), 0);
  endtask

  initial begin
    int base, n;
    logic [15:0] held;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready == 1'b0, in_ready, 0);
    chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("rst_data_out", data_out == 16'd0, data_out, 0);
    chk("rst_sat_flag", sat_flag == 1'b0, sat_flag, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready == 1'b1, in_ready, 1);
    tick();

    for (int k = 0; k < NT; k++) wr(k, k + 1);
    send(2048);
    for (int k = 0; k < NT - 1; k++) send(0);
    drain();

    for (int k = 0; k < NT; k++) wr(k, 4095);
    for (int k = 0; k < NT; k++) send(4095);
    drain();

    wr(0, 1);
    for (int k = 1; k < NT; k++) wr(k, 0);
    send(1024);
    send(1023);
    drain();

    for (int k = 0; k < NT; k++) wr(k, $urandom_range(0, 4095));
    send($urandom_range(0, 4095));
    wr(0, $urandom_range(0, 4095));
    wr(5, $urandom_range(0, 4095));
    wr(2, $urandom_range(0, 4095));
    wr(10, $urandom_range(0, 4095));
    drain();

    repeat (12) begin
      send($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, NT - 1), $urandom_range(0, 4095));
    end
    drain();

    hold = 1'b1;
    base = n_acc;
    n = 0;
    in_valid = 1'b1;
    while (n_acc < base + 5 && n < 200) begin
      data_in = 12'($urandom_range(0, 4095));
      tick(); n++;
    end
    in_valid = 1'b0;
    hold = 1'b0;
    chk("hold_acceptances", n_acc >= base + 5, n_acc - base, 5);
    drain();

    wr_s(0, 12'hFFF);
    send_s(100);
    drain();
    for (int k = 0; k < NT_S; k++) wr_s(k, 12'h800);
    repeat (NT_S) send_s(12'h800);
    repeat (NT_S) send_s(12'h7FF);
    repeat (8) begin
      wr_s($urandom_range(0, NT_S - 1), $urandom_range(0, 4095));
      send_s($urandom_range(0, 4095));
    end
    drain();

    for (int k = 0; k < NT; k++) wr(k, 4095);
    send(4000);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("abort_rst_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("abort_rst_data_out", data_out == 16'd0, data_out, 0);
    tick();
    rst = 1'b0;
    tick();
    send(4095);
    drain();
    for (int k = 0; k < NT; k++) wr(k, 4095);
    send(0);
    drain();

    held = data_out;
    send(1234);
    repeat (5) tick();
    en = 1'b0;
    @(negedge clk);
    chk("en_low_in_ready", in_ready == 1'b0, in_ready, 0);
    chk("en_low_data_held", data_out == held, data_out, held);
    tick();
    en = 1'b1;
    tick();
    send(2047);
    drain();
    repeat (25) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
